// File: rtl/sonic_rc_update_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sonic_rc_update_ctrl_pkg
// Purpose : shared constants for the RC update controller and the downstream
//           update stage. The state codes below are the values both blocks
//           agree on for cstate/nstate.
// Contents: state codes, default counter width, internal state enum.
// ---------------------------------------------------------------------------
package sonic_rc_update_ctrl_pkg;

    localparam int unsigned SC_START_TX    = 0;
    localparam int unsigned SC_MWR_REQ     = 1;
    localparam int unsigned SC_MWR_DV      = 2;
    localparam int unsigned SC_IDLE        = 3;
    localparam int unsigned SC_MWR_DONE    = 4;
    localparam int unsigned CNT_WIDTH_DEF  = 16;

    typedef enum logic [2:0] {
        ST_START_TX = 3'd0,
        ST_MWR_REQ  = 3'd1,
        ST_MWR_DV   = 3'd2,
        ST_IDLE     = 3'd3,
        ST_MWR_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/sonic_rc_update_ctrl_if.sv
// ---------------------------------------------------------------------------
// sonic_rc_update_ctrl_if
// Purpose : bundles the request, coalescing-config, backend handshake and
//           status signals of the RC update controller.
// Signals : cmd_req, evt_pulse            - update requests (pulses)
//           coal_thresh, coal_timeout     - coalescing configuration
//           tx_sel, tx_ack, tx_ws, tx_dv,
//           tx_dfr                        - arbiter / backend handshake
//           cstate, nstate, upd_done,
//           evt_count                     - status outputs
// Modports: master = requester/backend side, slave = the controller.
//
// Handshake: tx_sel is the arbiter grant, sampled only in START_TX. tx_ack
// is the backend accepting the descriptor, sampled only in MWR_REQ. In
// MWR_DV a beat completes only on a cycle with tx_dv=1 and tx_ws=0; the
// write is finished when such a beat also has tx_dfr=0 (no more data phase
// pending). Outside those states the handshake inputs are ignored.
// ---------------------------------------------------------------------------
interface sonic_rc_update_ctrl_if
    import sonic_rc_update_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
);
    logic                 cmd_req;
    logic                 evt_pulse;
    logic [CNT_WIDTH-1:0] coal_thresh;
    logic [CNT_WIDTH-1:0] coal_timeout;
    logic                 tx_sel;
    logic                 tx_ack;
    logic                 tx_ws;
    logic                 tx_dv;
    logic                 tx_dfr;
    logic [31:0]          cstate;
    logic [31:0]          nstate;
    logic                 upd_done;
    logic [CNT_WIDTH-1:0] evt_count;

    modport master (
        output cmd_req, evt_pulse, coal_thresh, coal_timeout,
               tx_sel, tx_ack, tx_ws, tx_dv, tx_dfr,
        input  cstate, nstate, upd_done, evt_count
    );

    modport slave (
        input  cmd_req, evt_pulse, coal_thresh, coal_timeout,
               tx_sel, tx_ack, tx_ws, tx_dv, tx_dfr,
        output cstate, nstate, upd_done, evt_count
    );

endinterface

// File: rtl/sonic_rc_update_ctrl.sv
// ---------------------------------------------------------------------------
// sonic_rc_update_ctrl
// Purpose : decides when a completion-ring update write must be issued and
//           walks it through grant, descriptor accept and data phase.
//           Requests (cmd_req, events) are latched into a pending flag;
//           pending, event count and timer are snapshotted (cleared) when
//           the write enters MWR_REQ, so anything arriving afterwards arms
//           the next update.
// Ports   : clk_in  - clock, rising edge
//           rstn    - asynchronous active-low reset
//           init    - asynchronous active-high soft clear
//           bus     - sonic_rc_update_ctrl_if.slave (requests, config,
//                     handshake, cstate/nstate/upd_done/evt_count)
// Config  : RC_UPD_COALESCE_EN - when defined, events are coalesced by
//           coal_thresh and the coal_timeout timer; when undefined every
//           event requests an update and the config inputs are ignored.
// ---------------------------------------------------------------------------
module sonic_rc_update_ctrl
    import sonic_rc_update_ctrl_pkg::*;
#(
    parameter int unsigned START_TX  = SC_START_TX,
    parameter int unsigned MWR_REQ   = SC_MWR_REQ,
    parameter int unsigned MWR_DV    = SC_MWR_DV,
    parameter int unsigned IDLE      = SC_IDLE,
    parameter int unsigned MWR_DONE  = SC_MWR_DONE,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
)(
    input  logic                   clk_in,
    input  logic                   rstn,
    input  logic                   init,
    sonic_rc_update_ctrl_if.slave  bus
);

    // Both clear sources act asynchronously through one reset net.
    logic w_arst_n;
    assign w_arst_n = rstn & ~init;

    state_e               r_state;
    logic                 r_pend;
    logic [CNT_WIDTH-1:0] r_evt_count;
    logic                 r_upd_done;

    state_e               w_nstate;
    logic                 w_enter_req;
    logic [CNT_WIDTH-1:0] w_cnt_base;
    logic [CNT_WIDTH:0]   w_cnt_sum;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 w_evt_set;
    logic                 w_pend_next;

    function automatic logic [31:0] f_code(input state_e s);
        logic [31:0] code;
        case (s)
            ST_START_TX: code = START_TX;
            ST_MWR_REQ:  code = MWR_REQ;
            ST_MWR_DV:   code = MWR_DV;
            ST_MWR_DONE: code = MWR_DONE;
            default:     code = IDLE;
        endcase
        return code;
    endfunction

    // Next-state decode.
    always_comb begin
        w_nstate = r_state;
        case (r_state)
            ST_IDLE:     if (r_pend)      w_nstate = ST_START_TX;
            ST_START_TX: if (bus.tx_sel)  w_nstate = ST_MWR_REQ;
            ST_MWR_REQ:  if (bus.tx_ack)  w_nstate = ST_MWR_DV;
            ST_MWR_DV:   if (bus.tx_dv && !bus.tx_ws && !bus.tx_dfr)
                                          w_nstate = ST_MWR_DONE;
            ST_MWR_DONE:                  w_nstate = ST_IDLE;
            default:                      w_nstate = ST_IDLE;
        endcase
    end

    // Snapshot point: pending state clears on the grant edge into MWR_REQ.
    assign w_enter_req = (r_state == ST_START_TX) && bus.tx_sel;

    // A coincident event lands after the clear, so it is counted as 1.
    assign w_cnt_base = w_enter_req ? '0 : r_evt_count;
    assign w_cnt_sum  = {1'b0, w_cnt_base} + {{CNT_WIDTH{1'b0}}, bus.evt_pulse};
    assign w_cnt_next = w_cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}}
                                             : w_cnt_sum[CNT_WIDTH-1:0];

`ifdef RC_UPD_COALESCE_EN
    logic [CNT_WIDTH-1:0] r_timer;
    logic [CNT_WIDTH-1:0] w_tmr_base;
    logic [CNT_WIDTH-1:0] w_tmr_next;
    logic                 w_tmr_run;
    logic                 w_tmr_expire;
    logic                 w_thresh_hit;

    // The timer runs from the edge where the count leaves zero; it holds
    // at all-ones rather than wrapping past the timeout.
    assign w_tmr_base   = w_enter_req ? '0 : r_timer;
    assign w_tmr_run    = (bus.coal_timeout != '0) && (w_cnt_next != '0);
    assign w_tmr_next   = !w_tmr_run ? '0
                        : (&w_tmr_base) ? w_tmr_base
                        : w_tmr_base + CNT_WIDTH'(1);
    assign w_tmr_expire = w_tmr_run && (w_tmr_next == bus.coal_timeout);
    assign w_thresh_hit = bus.evt_pulse &&
                          ((bus.coal_thresh == '0) || (w_cnt_next >= bus.coal_thresh));
    assign w_evt_set    = w_thresh_hit || w_tmr_expire;

    always_ff @(posedge clk_in or negedge w_arst_n) begin
        if (!w_arst_n) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_tmr_next;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{bus.coal_thresh, bus.coal_timeout};
    assign w_evt_set    = bus.evt_pulse;
`endif

    assign w_pend_next = (r_pend && !w_enter_req) || bus.cmd_req || w_evt_set;

    always_ff @(posedge clk_in or negedge w_arst_n) begin
        if (!w_arst_n) begin
            r_state     <= ST_IDLE;
            r_pend      <= 1'b0;
            r_evt_count <= '0;
            r_upd_done  <= 1'b0;
        end else begin
            r_state     <= w_nstate;
            r_pend      <= w_pend_next;
            r_evt_count <= w_cnt_next;
            // High for exactly the cycle the FSM sits in MWR_DONE.
            r_upd_done  <= (w_nstate == ST_MWR_DONE);
        end
    end

    assign bus.cstate    = f_code(r_state);
    assign bus.nstate    = w_arst_n ? f_code(w_nstate) : IDLE;
    assign bus.upd_done  = r_upd_done;
    assign bus.evt_count = r_evt_count;

endmodule

// File: doc/sonic_rc_update_ctrl.md
SONIC_RC_UPDATE_CTRL -- requirements
Module: sonic_rc_update_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line: START_TX, 0, state code; MWR_REQ, 1, state code; MWR_DV, 2, state code; IDLE, 3, state code; MWR_DONE, 4, state code; CNT_WIDTH, 16, event-counter and timer width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_in  in  1  sole clock; one clock, all logic on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- init  in  1  async soft clear, active-high.
- cmd_req  in  1  pulse; command-response update wanted, never coalesced.
- evt_pulse  in  1  pulse; one IRQ-worthy event (rx data, tx completion).
- coal_thresh  in  CNT_WIDTH  event count that forces an update; 0 means every event.
- coal_timeout  in  CNT_WIDTH  cycles from first pending event to forced update; 0 disables the timer.
- tx_sel  in  1  PCIe arbiter grant to this channel.
- tx_ack  in  1  backend accepted the descriptor.
- tx_ws  in  1  backend wait-state.
- tx_dv  in  1  data-valid driven by the downstream update stage.
- tx_dfr  in  1  data-phase-pending driven by the downstream update stage.
- cstate  out  32  current state, int unsigned.
- nstate  out  32  next state, combinational, int unsigned.
- upd_done  out  1  one-cycle pulse when a write completes.
- evt_count  out  CNT_WIDTH  events absorbed into the pending update.

Function
REQ-003 States: IDLE, START_TX, MWR_REQ, MWR_DV, MWR_DONE; cstate registers nstate every cycle.
REQ-004 IDLE->START_TX when pend is 1; otherwise stay.
REQ-005 START_TX->MWR_REQ when tx_sel is 1; otherwise hold indefinitely.
REQ-006 MWR_REQ->MWR_DV on the first cycle tx_ack is 1.
REQ-007 MWR_DV->MWR_DONE when tx_dv is 1, tx_ws is 0 and tx_dfr is 0 in the same cycle (last oword accepted).
REQ-008 MWR_DONE->IDLE unconditionally; upd_done is 1 exactly for the MWR_DONE cycle.
REQ-009 pend sets on: cmd_req; evt_count+increment >= coal_thresh with coal_thresh nonzero; timer expiry; any evt_pulse when coal_thresh is 0.
REQ-010 pend, evt_count and the timer clear on entry to MWR_REQ (the snapshot point).
REQ-011 Events or cmd_req arriving from MWR_REQ through MWR_DONE are counted or latched, and re-arm pend for the next update; none are lost.
REQ-012 evt_count saturates at all-ones and does not wrap.
REQ-013 The timer starts when evt_count leaves 0, increments each cycle, and expires when it equals coal_timeout; it is inactive when coal_timeout is 0.
REQ-014 When evt_pulse and the MWR_REQ entry clear coincide, the new event is counted as 1 after the clear.
REQ-015 Latency from cmd_req in IDLE to cstate==START_TX is 2 cycles (pend registered, then state).

Reset
REQ-016 rstn low or init high, asynchronously: cstate=IDLE, pend=0, evt_count=0, timer=0, upd_done=0, and nstate resolves to IDLE.
REQ-017 Reset mid-transfer abandons the write with no upd_done; the downstream stage relies on cstate leaving MWR_* to drop tx_req.

Configuration
REQ-018 Macro RC_UPD_COALESCE_EN: when defined, REQ-009 and REQ-013 apply.
REQ-019 When RC_UPD_COALESCE_EN is undefined, every evt_pulse sets pend directly, the timer is absent, coal_thresh and coal_timeout are ignored, and evt_count still counts.

Structure
REQ-020 State codes (IDLE, START_TX, MWR_REQ, MWR_DV, MWR_DONE) are defined in sonic_constants.sv as shared constants, with identical values passed to this block and the downstream update stage.
REQ-021 No sub-module is required; the coalescing counter and timer may be split into sonic_irq_coalesce if reused by another channel.

Verification
REQ-022 cmd_req pulse in IDLE, tx_sel high at cycle 3, tx_ack at 5, tx_dv=1/tx_ws=0/tx_dfr=0 at 7 -> states IDLE,START_TX,MWR_REQ,MWR_DV,MWR_DONE; upd_done at cycle 8.
REQ-023 RC_UPD_COALESCE_EN defined, coal_thresh=4, coal_timeout=0, 3 events -> stays IDLE; 4th event -> START_TX 2 cycles later; evt_count=4 until MWR_REQ.
REQ-024 coal_thresh=100, coal_timeout=10, 1 event -> START_TX reached 10 cycles after the timer starts.
REQ-025 2 events in MWR_DV -> after MWR_DONE returns to IDLE, then START_TX again with evt_count=2.
REQ-026 rstn low during MWR_DV -> cstate=IDLE immediately, no upd_done; 70000 events with no grant -> evt_count=16'hFFFF.
